// File: rtl/dmem_responder_if.sv
// Load/store port between the core datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, be, addr, wd,
        input  rd, ready, err, busy
    );

    modport slave (
        input  req, we, be, addr, wd,
        output rd, ready, err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: one outstanding load/store at a time, completion
// signalled by a one-cycle ready pulse LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_rd;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic          w_enter_resp;
    logic          w_commit;
    logic          w_op_we;
    logic [3:0]    w_op_be;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wd;
    logic          w_op_err;
    logic [AW-1:0] w_op_idx;

    // With LATENCY=1 the commit happens on the accepting edge, so use the live request.
    assign w_op_we   = (r_state == StIdle) ? bus.we   : r_we;
    assign w_op_be   = (r_state == StIdle) ? bus.be   : r_be;
    assign w_op_addr = (r_state == StIdle) ? bus.addr : r_addr;
    assign w_op_wd   = (r_state == StIdle) ? bus.wd   : r_wd;

    assign w_op_err = (w_op_addr[1:0] != 2'b00) || ({2'b00, w_op_addr[31:2]} >= 32'(DEPTH));
    assign w_op_idx = w_op_addr[AW+1:2];
    assign w_commit = w_enter_resp && !reset;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req) begin
                    if (LATENCY == 1) begin
                        w_state_next = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = StWait;
                        w_cnt_next   = 4'(LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StResp;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wd    <= 32'd0;
            r_rd    <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if ((r_state == StIdle) && bus.req) begin
                r_we   <= bus.we;
                r_be   <= bus.be;
                r_addr <= bus.addr;
                r_wd   <= bus.wd;
            end
            if (w_enter_resp) begin
                r_err <= w_op_err;
                if (w_op_err) begin
                    r_rd <= 32'd0;
                end else if (!w_op_we) begin
                    r_rd <= r_mem[w_op_idx];
                end
            end
        end
    end

    // RAM array is deliberately not reset; a held reset blocks the commit.
    always_ff @(posedge clk) begin
        if (w_commit && w_op_we && !w_op_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_op_idx][8*i +: 8] <= w_op_wd[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready = (r_state == StResp);
    assign bus.err   = (r_state == StResp) && r_err;
    assign bus.busy  = (r_state != StIdle);
    assign bus.rd    = r_rd;
endmodule
